// File: rtl/msg_frame_fifo.sv
// msg_frame_fifo: assembles 5-beat x 64-bit feed frames into 320-bit order
// messages and buffers them in a DEPTH-entry FIFO. Short and long frames are
// dropped and counted in a saturating error counter.
// Optional build macro MSG_FILTER_EN: only message types 0x53, 0x44, 0x45 are
// stored; other types are dropped and counted as errors.
module msg_frame_fifo #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    output logic         in_ready,
    input  logic         pop,
    output logic         buffer_not_empty,
    output logic [319:0] ff_buffer,
    output logic         buffer_full,
    output logic [4:0]   msg_count,
    output logic [7:0]   err_count
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic {
        ASSEMBLE,
        DISCARD
    } state_t;

    state_t         state, state_next;
    logic [2:0]     beat_idx, beat_next;
    logic [319:0]   asm_reg;
    logic [319:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           accept, push, pop_en, err_inc, type_ok;

    assign accept           = in_valid && in_ready;
    assign pop_en           = pop && buffer_not_empty;
    assign buffer_not_empty = (msg_count != 5'd0);
    assign buffer_full      = (msg_count == DEPTH_C);
    // Back-pressure depends only on registered state, never on pop.
    assign in_ready         = !((state == ASSEMBLE) && (beat_idx == 3'd4) && buffer_full);
    assign ff_buffer        = buffer_not_empty ? mem[rd_ptr] : '0;

`ifdef MSG_FILTER_EN
    // Type byte was captured from beat 0 and is already in the assembly register.
    assign type_ok = (asm_reg[319:312] == 8'h53) || (asm_reg[319:312] == 8'h44) ||
                     (asm_reg[319:312] == 8'h45);
`else
    assign type_ok = 1'b1;
`endif

    // FSM state and beat index register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ASSEMBLE;
            beat_idx <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state    <= state_next;
            beat_idx <= beat_next;
        end
    end

    // Next-state logic plus push / error strobes for the current beat.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a latch behind.
        state_next = state;
        beat_next  = beat_idx;
        push       = 1'b0;
        err_inc    = 1'b0;
        if (accept) begin
            case (state)
                ASSEMBLE: begin
                    if (beat_idx == 3'd4) begin
                        beat_next = 3'd0;
                        if (in_last) begin
                            push    = type_ok;
                            err_inc = !type_ok;
                        end else begin
                            state_next = DISCARD;
                            err_inc    = 1'b1;
                        end
                    end else if (in_last) begin
                        beat_next = 3'd0;
                        err_inc   = 1'b1;
                    end else begin
                        beat_next = beat_idx + 3'd1;
                    end
                end
                DISCARD: begin
                    if (in_last) begin
                        state_next = ASSEMBLE;
                    end
                end
                default: state_next = ASSEMBLE;
            endcase
        end
    end

    // Capture beats 0..3 into their slice of the assembly register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_reg <= '0;
        end else if (accept && (state == ASSEMBLE)) begin
            case (beat_idx)
                3'd0:    asm_reg[319:256] <= in_data;
                3'd1:    asm_reg[255:192] <= in_data;
                3'd2:    asm_reg[191:128] <= in_data;
                3'd3:    asm_reg[127:64]  <= in_data;
                default: ;
            endcase
        end
    end

    // FIFO storage; beat 4 goes straight into the entry alongside beats 0..3.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; ff_buffer gating hides stale entries.
        if (push) begin
            mem[wr_ptr] <= {asm_reg[319:64], in_data};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            msg_count <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_en})
                2'b10:   msg_count <= msg_count + 5'd1;
                2'b01:   msg_count <= msg_count - 5'd1;
                default: ;
            endcase
        end
    end

    // Dropped-frame counter, saturating at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (err_inc && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_msg_frame_fifo.sv
// Directed testbench for msg_frame_fifo (DEPTH = 4). Inputs change and outputs
// are sampled 1 ns after the rising edge.
module tb_msg_frame_fifo;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [63:0]  in_data;
    logic         in_last;
    logic         in_ready;
    logic         pop;
    logic         buffer_not_empty;
    logic [319:0] ff_buffer;
    logic         buffer_full;
    logic [4:0]   msg_count;
    logic [7:0]   err_count;

    int passed = 0;
    int total  = 0;

    msg_frame_fifo #(.DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .pop              (pop),
        .buffer_not_empty (buffer_not_empty),
        .ff_buffer        (ff_buffer),
        .buffer_full      (buffer_full),
        .msg_count        (msg_count),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    // Beat 0 = {type, id, 0..., 0x01}; beat i>0 = {id, 0..., i+1}.
    function automatic logic [63:0] beat_data(input logic [7:0] t, input logic [7:0] id, input int i);
        if (i == 0) return {t, id, 40'h0, 8'h01};
        return {id, 48'h0, 8'(i + 1)};
    endfunction

    function automatic logic [319:0] exp_msg(input logic [7:0] t, input logic [7:0] id);
        return {beat_data(t, id, 0), beat_data(t, id, 1), beat_data(t, id, 2),
                beat_data(t, id, 3), beat_data(t, id, 4)};
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic l);
        int waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL beat_accept_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends n beats; in_last on beat n-1.
    task automatic send_frame(input logic [7:0] t, input logic [7:0] id, input int n);
        for (int i = 0; i < n; i++) send_beat(beat_data(t, id, i), (i == n - 1));
    endtask

    task automatic do_pop;
        pop = 1'b1;
        @(posedge clk); #1;
        pop = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; pop = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", in_ready); else passed++;
        total++; if (buffer_not_empty !== 1'b0) $display("FAIL reset_not_empty got %0b exp 0", buffer_not_empty); else passed++;
        total++; if (ff_buffer !== '0) $display("FAIL reset_ff_buffer got %h exp 0", ff_buffer); else passed++;
        total++; if (buffer_full !== 1'b0) $display("FAIL reset_full got %0b exp 0", buffer_full); else passed++;
        total++; if (msg_count !== 5'd0) $display("FAIL reset_msg_count got %0d exp 0", msg_count); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL reset_err_count got %0d exp 0", err_count); else passed++;
    endtask

    task automatic test_single_frame;
        send_frame(8'h53, 8'h00, 5);
        total++; if (buffer_not_empty !== 1'b1) $display("FAIL single_not_empty got %0b exp 1", buffer_not_empty); else passed++;
        total++; if (ff_buffer[319:312] !== 8'h53) $display("FAIL single_type got %h exp 53", ff_buffer[319:312]); else passed++;
        total++; if (ff_buffer[63:0] !== 64'h5) $display("FAIL single_low got %h exp 5", ff_buffer[63:0]); else passed++;
        total++; if (ff_buffer !== exp_msg(8'h53, 8'h00)) $display("FAIL single_msg got %h exp %h", ff_buffer, exp_msg(8'h53, 8'h00)); else passed++;
        total++; if (msg_count !== 5'd1) $display("FAIL single_count got %0d exp 1", msg_count); else passed++;
        do_pop();
        total++; if (ff_buffer !== '0 || buffer_not_empty !== 1'b0) $display("FAIL single_pop_empty got ne=%0b buf=%h exp ne=0 buf=0", buffer_not_empty, ff_buffer); else passed++;
    endtask

    task automatic test_full;
        for (int f = 1; f <= 4; f++) send_frame(8'h44, 8'(f), 5);
        total++; if (buffer_full !== 1'b1 || msg_count !== 5'd4) $display("FAIL full_flag got full=%0b cnt=%0d exp full=1 cnt=4", buffer_full, msg_count); else passed++;
        total++; if (ff_buffer !== exp_msg(8'h44, 8'd1)) $display("FAIL full_head got %h exp %h", ff_buffer, exp_msg(8'h44, 8'd1)); else passed++;
        for (int i = 0; i < 4; i++) send_beat(beat_data(8'h44, 8'd5, i), 1'b0);
        in_valid = 1'b1; in_data = beat_data(8'h44, 8'd5, 4); in_last = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        total++; if (in_ready !== 1'b0 || msg_count !== 5'd4) $display("FAIL full_stall got rdy=%0b cnt=%0d exp rdy=0 cnt=4", in_ready, msg_count); else passed++;
        do_pop();
        total++; if (in_ready !== 1'b1 || msg_count !== 5'd3) $display("FAIL full_after_pop got rdy=%0b cnt=%0d exp rdy=1 cnt=3", in_ready, msg_count); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (msg_count !== 5'd4) $display("FAIL full_refill got %0d exp 4", msg_count); else passed++;
        for (int f = 2; f <= 5; f++) begin
            total++; if (ff_buffer !== exp_msg(8'h44, 8'(f))) $display("FAIL full_order%0d got %h exp %h", f, ff_buffer, exp_msg(8'h44, 8'(f))); else passed++;
            do_pop();
        end
        total++; if (msg_count !== 5'd0 || buffer_not_empty !== 1'b0) $display("FAIL full_drained got cnt=%0d ne=%0b exp cnt=0 ne=0", msg_count, buffer_not_empty); else passed++;
    endtask

    task automatic test_short_frame;
        send_frame(8'h45, 8'd20, 4);
        total++; if (err_count !== 8'd1 || msg_count !== 5'd0) $display("FAIL short_drop got err=%0d cnt=%0d exp err=1 cnt=0", err_count, msg_count); else passed++;
        send_frame(8'h45, 8'd6, 5);
        total++; if (msg_count !== 5'd1 || ff_buffer !== exp_msg(8'h45, 8'd6)) $display("FAIL short_next got cnt=%0d buf=%h exp cnt=1 buf=%h", msg_count, ff_buffer, exp_msg(8'h45, 8'd6)); else passed++;
        do_pop();
    endtask

    task automatic test_long_frame;
        send_frame(8'h53, 8'd21, 7);
        total++; if (err_count !== 8'd2 || msg_count !== 5'd0) $display("FAIL long_drop got err=%0d cnt=%0d exp err=2 cnt=0", err_count, msg_count); else passed++;
        send_frame(8'h53, 8'd7, 5);
        total++; if (msg_count !== 5'd1 || ff_buffer !== exp_msg(8'h53, 8'd7)) $display("FAIL long_next got cnt=%0d buf=%h exp cnt=1 buf=%h", msg_count, ff_buffer, exp_msg(8'h53, 8'd7)); else passed++;
        total++; if (err_count !== 8'd2) $display("FAIL long_err_stable got %0d exp 2", err_count); else passed++;
        do_pop();
    endtask

    task automatic test_back_to_back;
        do_pop();
        total++; if (msg_count !== 5'd0 || buffer_not_empty !== 1'b0) $display("FAIL pop_empty got cnt=%0d ne=%0b exp cnt=0 ne=0", msg_count, buffer_not_empty); else passed++;
        send_frame(8'h44, 8'd8, 5);
        send_frame(8'h44, 8'd9, 5);
        for (int i = 0; i < 4; i++) send_beat(beat_data(8'h45, 8'd10, i), 1'b0);
        in_valid = 1'b1; in_data = beat_data(8'h45, 8'd10, 4); in_last = 1'b1; pop = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; pop = 1'b0;
        total++; if (msg_count !== 5'd2 || ff_buffer !== exp_msg(8'h44, 8'd9)) $display("FAIL pushpop got cnt=%0d buf=%h exp cnt=2 buf=%h", msg_count, ff_buffer, exp_msg(8'h44, 8'd9)); else passed++;
        do_pop();
        total++; if (ff_buffer !== exp_msg(8'h45, 8'd10)) $display("FAIL pushpop_order got %h exp %h", ff_buffer, exp_msg(8'h45, 8'd10)); else passed++;
        do_pop();
    endtask

    task automatic test_filter;
        send_frame(8'h41, 8'd11, 5);
`ifdef MSG_FILTER_EN
        total++; if (msg_count !== 5'd0 || err_count !== 8'd3) $display("FAIL filter_drop got cnt=%0d err=%0d exp cnt=0 err=3", msg_count, err_count); else passed++;
`else
        total++; if (msg_count !== 5'd1 || err_count !== 8'd2 || ff_buffer !== exp_msg(8'h41, 8'd11)) $display("FAIL filter_pass got cnt=%0d err=%0d buf=%h exp cnt=1 err=2", msg_count, err_count, ff_buffer); else passed++;
        do_pop();
`endif
    endtask

    task automatic test_err_saturate;
        for (int i = 0; i < 260; i++) send_beat(64'hDEAD, 1'b1);
        total++; if (err_count !== 8'hFF) $display("FAIL err_saturate got %0d exp 255", err_count); else passed++;
    endtask

    task automatic test_reset_mid_frame;
        send_beat(beat_data(8'h53, 8'd12, 0), 1'b0);
        send_beat(beat_data(8'h53, 8'd12, 1), 1'b0);
        #2 reset = 1'b1;
        #1;
        total++; if (err_count !== 8'd0 || msg_count !== 5'd0) $display("FAIL async_reset got err=%0d cnt=%0d exp err=0 cnt=0", err_count, msg_count); else passed++;
        @(posedge clk); #1 reset = 1'b0;
        send_frame(8'h53, 8'd13, 5);
        total++; if (msg_count !== 5'd1 || ff_buffer !== exp_msg(8'h53, 8'd13) || err_count !== 8'd0) $display("FAIL reset_restart got cnt=%0d err=%0d buf=%h exp cnt=1 err=0 buf=%h", msg_count, err_count, ff_buffer, exp_msg(8'h53, 8'd13)); else passed++;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_full();
        test_short_frame();
        test_long_frame();
        test_back_to_back();
        test_filter();
        test_err_saturate();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/msg_frame_fifo.md
# msg_frame_fifo

Upstream neighbour of the order parser. Accepts the 64-bit market-feed beat stream, assembles each 5-beat frame into a 320-bit order message, and buffers completed messages in a small FIFO. The FIFO head is presented as `ff_buffer` and `buffer_not_empty`. Malformed frames are dropped and counted, so the parser only ever sees whole, correctly sized messages.

## Interface
- `DEPTH`, default 4: FIFO entries, power of two, 2..16.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `in_valid` input 1: beat valid.
- `in_data` input 64: beat payload; first beat of a frame is message bits [319:256].
- `in_last` input 1: marks final beat of a frame.
- `in_ready` output 1: beat accepted when `in_valid && in_ready`.
- `pop` input 1: consumer has taken the head message; ignored when empty.
- `buffer_not_empty` output 1: head message valid.
- `ff_buffer` output 320: head message; all-zero when empty.
- `buffer_full` output 1: count == DEPTH.
- `msg_count` output 5: messages stored, 0..DEPTH.
- `err_count` output 8: dropped-frame counter, saturates at 255.

## Operation
- Reset values: `in_ready`=1, `buffer_not_empty`=0, `ff_buffer`=0, `buffer_full`=0, `msg_count`=0, `err_count`=0. Pointers and beat index are 0, and the FSM is in ASSEMBLE.
- FSM states: ASSEMBLE (beat index 0..4) and DISCARD.
- ASSEMBLE, accepted beat k, k=0..3:
  - Write `in_data` into assembly register slice [319-64k -: 64].
  - If `in_last`: short frame. Drop the partial, increment `err_count`, beat index returns to 0 and the FSM stays in ASSEMBLE.
- ASSEMBLE, accepted beat 4:
  - If `in_last`: push the full 320-bit message into the FIFO at the write pointer. Beat index returns to 0.
  - If not `in_last`: long frame. Drop the frame, increment `err_count`, go to DISCARD.
- DISCARD: accept and drop beats until a beat with `in_last` is accepted, then return to ASSEMBLE with beat index 0. No further increments to `err_count` for the same frame.
- `in_ready` is 0 only when the FSM is in ASSEMBLE, beat index == 4 and `msg_count` == DEPTH. `pop` is not considered, so there is no combinational path from `pop` to `in_ready`.
- Pop: when `pop && buffer_not_empty`, advance the read pointer. `pop` while empty has no effect.
- Push and pop in the same cycle leave `msg_count` unchanged. Push and pop each act on their own pointer.
- Pointers wrap modulo DEPTH. The full/empty decision uses `msg_count` only.
- Arithmetic: `err_count` saturates at 255 and never wraps.

## Timing
- A message pushed on edge N is visible on `ff_buffer` with `buffer_not_empty`=1 after edge N. Latency from the 5th accepted beat to visible output is 1 cycle.
- After a pop on edge N, the next entry (or zeros plus `buffer_not_empty`=0) is visible after edge N.
- `ff_buffer` is a combinational read of the head entry, gated to zero when empty. Storage itself is not reset.
- Sustained throughput: one message per 5 cycles when not full. Back-to-back frames need no idle beats.
- Reset asserted mid-frame or mid-DISCARD: all state clears asynchronously. The partial frame is lost without an `err_count` increment. The first beat after reset release is treated as beat 0.

## Configuration
- `MSG_FILTER_EN`
  - Defined: a completed message is pushed only if byte [319:312] is 0x53, 0x44 or 0x45. Any other type is dropped and increments `err_count`, with no FIFO write.
  - Undefined: every correctly sized frame is pushed, regardless of type.

## Test plan
- Frame 1: beats 0x5300…01, 0x02, 0x03, 0x04, 0x05 with `in_last` on beat 5 -> one cycle later `buffer_not_empty`=1, `ff_buffer`[319:312]=0x53, `ff_buffer`[63:0]=0x05, `msg_count`=1.
- DEPTH=4: push 4 frames with no pop, then send a 5th frame -> `buffer_full`=1, and `in_ready`=0 on the 5th beat. `pop` once -> beat accepted, `msg_count` stays 4.
- Frame with `in_last` on beat 3 -> `err_count`=1, nothing pushed. Next valid 5-beat frame is pushed intact.
- 7-beat frame with `in_last` on beat 7 -> `err_count`=1, 7 beats all accepted, then a following 5-beat frame is pushed correctly.
- `pop` on empty, then push and pop in the same cycle with `msg_count`=2 -> no change when empty, then `msg_count` stays 2 with FIFO order preserved.
- With `MSG_FILTER_EN` defined, a frame with type byte 0x41 -> not pushed, `err_count`+1. Without the macro the same frame is pushed.
